// File: rtl/rv32i_control_fsm.sv
// Multi-cycle RV32I control unit.
// The unit fetches an instruction over a req/ack port and decodes it into the
// ALU control bundle and the operand selects. It sequences the memory and
// writeback phases and owns the program counter.
module rv32i_control_fsm #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [2:0]  dmem_funct3,
  input  logic        dmem_ack,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic [1:0]  rd_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [31:0] imm,
  output logic [2:0]  funct3_,
  output logic [6:0]  funct7_,
  output logic [3:0]  instr_type,
  input  logic [31:0] alu_c,
  output logic [31:0] pc,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] T_R = 4'd0;
  localparam logic [3:0] T_I = 4'd1;
  localparam logic [3:0] T_S = 4'd2;
  localparam logic [3:0] T_B = 4'd3;
  localparam logic [3:0] T_U = 4'd4;
  localparam logic [3:0] T_J = 4'd5;
  localparam logic [3:0] T_N = 4'd7;

  typedef enum logic [2:0] {
    st_fetch, st_decode, st_exec, st_mem, st_wb, st_halt
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ir_reg, ir_next;
  logic [31:0] result_reg, result_next;
  logic [31:0] npc_reg, npc_next;
  logic        illegal_reg, illegal_next;
  logic        squash_reg, squash_next;
  logic        wr_reg, wr_next;
  logic        first_reg;
  logic [2:0]  funct3_reg, funct3_next;
  logic [6:0]  funct7_reg, funct7_next;
  logic [3:0]  type_reg, type_next;
  logic [31:0] imm_reg, imm_next;
  logic        asel_reg, asel_next;
  logic        bsel_reg, bsel_next;
  logic [1:0]  rdsel_reg, rdsel_next;

  logic [6:0]  opcode;
  logic [2:0]  ir_f3;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_legal;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4, target;
  logic        jump, misaligned;

  assign opcode    = ir_reg[6:0];
  assign ir_f3     = ir_reg[14:12];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_legal  = (opcode == OPC_OP) || (opcode == OPC_OPIMM) || is_load ||
                     is_store || is_branch || is_jal || is_jalr ||
                     (opcode == OPC_LUI) || (opcode == OPC_AUIPC);

  assign imm_i = {{20{ir_reg[31]}}, ir_reg[31:20]};
  assign imm_s = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
  assign imm_b = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
  assign imm_u = {ir_reg[31:12], 12'h000};
  assign imm_j = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};

  assign pc_plus4 = pc_reg + 32'd4;

  // Resolve the control-transfer target from the ALU result during EXEC;
  // branch targets come from pc+imm since the ALU is busy comparing.
  always_comb begin
    jump   = 1'b0;
    target = pc_plus4;
    if (is_jal) begin
      jump   = 1'b1;
      target = alu_c;
    end else if (is_jalr) begin
      jump   = 1'b1;
      target = alu_c & ~32'd1;
    end else if (is_branch && alu_c[0]) begin
      jump   = 1'b1;
      target = pc_reg + imm_reg;
    end
  end

  assign misaligned = jump && target[1];

  // Next-state, decode and handshake strobes
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    result_next  = result_reg;
    npc_next     = npc_reg;
    illegal_next = illegal_reg;
    squash_next  = squash_reg;
    wr_next      = wr_reg;
    funct3_next  = funct3_reg;
    funct7_next  = funct7_reg;
    type_next    = type_reg;
    imm_next     = imm_reg;
    asel_next    = asel_reg;
    bsel_next    = bsel_reg;
    rdsel_next   = rdsel_reg;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rd_we        = 1'b0;

    case (state_reg)
      st_fetch: begin
        // The first cycle out of reset neither requests nor accepts an ack.
        imem_req = !first_reg;
        if (!first_reg && imem_ack) begin
          ir_next    = imem_rdata;
          state_next = st_decode;
        end
      end

      st_decode: begin
        funct3_next = 3'd0;
        funct7_next = 7'd0;
        type_next   = T_N;
        imm_next    = 32'd0;
        asel_next   = 1'b0;
        bsel_next   = 1'b0;
        rdsel_next  = 2'd0;
        wr_next     = 1'b0;
        case (opcode)
          OPC_OP: begin
            type_next   = T_R;
            funct3_next = ir_f3;
            funct7_next = ir_reg[31:25];
            wr_next     = 1'b1;
          end
          OPC_OPIMM: begin
            type_next   = T_I;
            funct3_next = ir_f3;
            bsel_next   = 1'b1;
            wr_next     = 1'b1;
            // Shifts carry funct7 and a 5-bit shamt rather than a full imm.
            if (ir_f3 == 3'b001 || ir_f3 == 3'b101) begin
              funct7_next = ir_reg[31:25];
              imm_next    = {27'd0, ir_reg[24:20]};
            end else begin
              imm_next    = imm_i;
            end
          end
          OPC_LOAD: begin
            type_next  = T_S;
            bsel_next  = 1'b1;
            imm_next   = imm_i;
            rdsel_next = 2'd1;
            wr_next    = 1'b1;
          end
          OPC_STORE: begin
            type_next = T_S;
            bsel_next = 1'b1;
            imm_next  = imm_s;
          end
          OPC_JALR: begin
            type_next  = T_S;
            bsel_next  = 1'b1;
            imm_next   = imm_i;
            rdsel_next = 2'd2;
            wr_next    = 1'b1;
          end
          OPC_BRANCH: begin
            type_next   = T_B;
            funct3_next = ir_f3;
            imm_next    = imm_b;
          end
          OPC_LUI: begin
            type_next = T_U;
            bsel_next = 1'b1;
            imm_next  = imm_u;
            wr_next   = 1'b1;
          end
          OPC_AUIPC: begin
            type_next = T_J;
            asel_next = 1'b1;
            bsel_next = 1'b1;
            imm_next  = imm_u;
            wr_next   = 1'b1;
          end
          OPC_JAL: begin
            type_next  = T_J;
            asel_next  = 1'b1;
            bsel_next  = 1'b1;
            imm_next   = imm_j;
            rdsel_next = 2'd2;
            wr_next    = 1'b1;
          end
          default: ;
        endcase
        state_next = st_exec;
      end

      st_exec: begin
        result_next = alu_c;
        squash_next = 1'b0;
        npc_next    = pc_plus4;
        if (!is_legal || misaligned) begin
          // Faulting instruction: either stop with pc untouched, or retire
          // as a NOP that skips to the next word without writing rd.
          illegal_next = 1'b1;
          squash_next  = 1'b1;
          if (HALT_ON_ILLEGAL) state_next = st_halt;
          else                 state_next = st_wb;
        end else if (is_load || is_store) begin
          state_next = st_mem;
        end else begin
          npc_next   = target;
          state_next = st_wb;
        end
      end

      st_mem: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) state_next = st_wb;
      end

      st_wb: begin
        rd_we      = wr_reg && (ir_reg[11:7] != 5'd0) && !squash_reg;
        pc_next    = npc_reg;
        state_next = st_fetch;
      end

      st_halt: ;

      default: state_next = st_fetch;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= st_fetch;
      pc_reg      <= RESET_PC;
      ir_reg      <= 32'd0;
      result_reg  <= 32'd0;
      npc_reg     <= 32'd0;
      illegal_reg <= 1'b0;
      squash_reg  <= 1'b0;
      wr_reg      <= 1'b0;
      first_reg   <= 1'b1;
      funct3_reg  <= 3'd0;
      funct7_reg  <= 7'd0;
      type_reg    <= T_N;
      imm_reg     <= 32'd0;
      asel_reg    <= 1'b0;
      bsel_reg    <= 1'b0;
      rdsel_reg   <= 2'd0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      result_reg  <= result_next;
      npc_reg     <= npc_next;
      illegal_reg <= illegal_next;
      squash_reg  <= squash_next;
      wr_reg      <= wr_next;
      first_reg   <= 1'b0;
      funct3_reg  <= funct3_next;
      funct7_reg  <= funct7_next;
      type_reg    <= type_next;
      imm_reg     <= imm_next;
      asel_reg    <= asel_next;
      bsel_reg    <= bsel_next;
      rdsel_reg   <= rdsel_next;
    end
  end

  assign imem_addr   = pc_reg;
  assign dmem_addr   = result_reg;
  assign dmem_funct3 = ir_reg[14:12];
  assign rs1_addr    = ir_reg[19:15];
  assign rs2_addr    = ir_reg[24:20];
  assign rd_addr     = ir_reg[11:7];
  assign rd_sel      = rdsel_reg;
  assign alu_a_sel   = asel_reg;
  assign alu_b_sel   = bsel_reg;
  assign imm         = imm_reg;
  assign funct3_     = funct3_reg;
  assign funct7_     = funct7_reg;
  assign instr_type  = type_reg;
  assign pc          = pc_reg;
  assign illegal     = illegal_reg;

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Scoreboard bench for rv32i_control_fsm: the driver pushes the expected
// behaviour of each instruction, a monitor pops it at the fetch handshake and
// checks writeback, memory access, decode outputs and the next pc.
module tb_rv32i_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr;
  logic [2:0]  dmem_funct3;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_we;
  logic [1:0]  rd_sel;
  logic        alu_a_sel, alu_b_sel;
  logic [31:0] imm;
  logic [2:0]  funct3_;
  logic [6:0]  funct7_;
  logic [3:0]  instr_type;
  logic [31:0] alu_c;
  logic [31:0] pc;
  logic        illegal;

  always #5 clk = ~clk;

  rv32i_control_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_funct3(dmem_funct3),
    .dmem_ack(dmem_ack),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rd_we(rd_we), .rd_sel(rd_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .imm(imm), .funct3_(funct3_), .funct7_(funct7_), .instr_type(instr_type),
    .alu_c(alu_c), .pc(pc), .illegal(illegal)
  );

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [3:0]  itype;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        asel;
    logic        bsel;
    logic [1:0]  rdsel;
    int          nwr;
    logic [4:0]  rd;
    int          lat;
    logic        mem;
    logic        mwe;
    logic [2:0]  mf3;
    logic [31:0] maddr;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   busy = 1'b0;
  bit   flush_req = 1'b0;
  int   cyc = 0;
  int   wr = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [31:0] p, input logic [31:0] np,
                              input logic [3:0] t, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] im, input logic a, input logic b,
                              input logic [1:0] rs, input int nw, input logic [4:0] rd,
                              input int lat, input logic ill);
    exp_t e;
    e.id = id; e.pc = p; e.npc = np; e.itype = t; e.f3 = f3; e.f7 = f7; e.imm = im;
    e.asel = a; e.bsel = b; e.rdsel = rs; e.nwr = nw; e.rd = rd; e.lat = lat;
    e.mem = 1'b0; e.mwe = 1'b0; e.mf3 = 3'd0; e.maddr = 32'd0; e.ill = ill;
    return e;
  endfunction

  // Close out the instruction in flight: decode outputs are still held and
  // pc already shows the next fetch address.
  task automatic finalize();
    chk($sformatf("i%0d instr_type", cur.id), 32'(instr_type), 32'(cur.itype));
    chk($sformatf("i%0d funct3_", cur.id), 32'(funct3_), 32'(cur.f3));
    chk($sformatf("i%0d funct7_", cur.id), 32'(funct7_), 32'(cur.f7));
    chk($sformatf("i%0d imm", cur.id), imm, cur.imm);
    chk($sformatf("i%0d alu_a_sel", cur.id), 32'(alu_a_sel), 32'(cur.asel));
    chk($sformatf("i%0d alu_b_sel", cur.id), 32'(alu_b_sel), 32'(cur.bsel));
    chk($sformatf("i%0d rd_sel", cur.id), 32'(rd_sel), 32'(cur.rdsel));
    chk($sformatf("i%0d rd_we_count", cur.id), 32'(wr), 32'(cur.nwr));
    chk($sformatf("i%0d next_pc", cur.id), pc, cur.npc);
    chk($sformatf("i%0d illegal", cur.id), 32'(illegal), 32'(cur.ill));
    $display("txn %0d pc=%h next_pc=%h rd_writes=%0d illegal=%0d", cur.id, cur.pc, pc, wr, illegal);
  endtask

  // Monitor: pops expectations at each fetch handshake and checks outputs
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        if (busy) cyc++;
        if (busy && rd_we) begin
          wr++;
          chk($sformatf("i%0d rd_addr", cur.id), 32'(rd_addr), 32'(cur.rd));
          chk($sformatf("i%0d wb_rd_sel", cur.id), 32'(rd_sel), 32'(cur.rdsel));
          chk($sformatf("i%0d wb_latency", cur.id), 32'(cyc), 32'(cur.lat));
        end
        if (busy && dmem_req && dmem_ack) begin
          chk($sformatf("i%0d mem_expected", cur.id), 32'(1), 32'(cur.mem));
          chk($sformatf("i%0d dmem_addr", cur.id), dmem_addr, cur.maddr);
          chk($sformatf("i%0d dmem_we", cur.id), 32'(dmem_we), 32'(cur.mwe));
          chk($sformatf("i%0d dmem_funct3", cur.id), 32'(dmem_funct3), 32'(cur.mf3));
        end
        if (imem_req && imem_ack) begin
          if (busy) finalize();
          if (q.size() == 0) begin
            chk("unexpected_fetch", 32'(q.size()), 32'(1));
            busy = 1'b0;
          end else begin
            cur  = q.pop_front();
            busy = 1'b1;
            cyc  = 0;
            wr   = 0;
            chk($sformatf("i%0d fetch_addr", cur.id), imem_addr, cur.pc);
          end
        end else if (flush_req && busy) begin
          finalize();
          busy = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] instr, input logic [31:0] aluc, input int mwait, input exp_t e);
    int n = 0;
    while (!imem_req && n < 40) begin @(posedge clk); #1; n++; end
    chk($sformatf("i%0d fetch_req", e.id), 32'(imem_req), 32'(1));
    if (!imem_req) return;
    q.push_back(e);
    alu_c      = aluc;
    imem_rdata = instr;
    imem_ack   = 1'b1;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    if (e.mem) begin
      n = 0;
      while (!dmem_req && n < 40) begin @(posedge clk); #1; n++; end
      chk($sformatf("i%0d dmem_req", e.id), 32'(dmem_req), 32'(1));
      if (!dmem_req) return;
      repeat (mwait) begin @(posedge clk); #1; end
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 40) begin @(posedge clk); #1; n++; end
    chk("next_fetch_req", 32'(imem_req), 32'(1));
  endtask

  task automatic flush();
    flush_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush_req = 1'b0;
  endtask

  task automatic check_halt();
    int seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req) seen++;
    end
    chk("halt_imem_req_cycles", 32'(seen), 32'(0));
    chk("halt_illegal", 32'(illegal), 32'(1));
  endtask

  task automatic do_reset(input bit spurious);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_illegal", 32'(illegal), 32'(0));
    chk("rst_instr_type", 32'(instr_type), 32'(7));
    chk("rst_imm", imm, 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'(0));
    chk("rst_dmem_req", 32'(dmem_req), 32'(0));
    chk("rst_rd_we", 32'(rd_we), 32'(0));
    chk("rst_rs_addr", 32'({rs1_addr, rs2_addr, rd_addr}), 32'(0));
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    if (spurious) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_007F;
    end
    @(negedge clk);
    chk("first_cycle_imem_req", 32'(imem_req), 32'(0));
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
  endtask

  initial begin
    exp_t e;
    imem_ack = 1'b0; imem_rdata = 32'd0; dmem_ack = 1'b0; alu_c = 32'd0;
    do_reset(1'b0);

    issue(32'h002081B3, 32'h55, 0, mk(1, 32'h0, 32'h4, 4'd0, 3'd0, 7'h00, 32'h0, 0, 0, 2'd0, 1, 5'd3, 3, 0));
    issue(32'h4032D293, 32'h1, 0, mk(2, 32'h4, 32'h8, 4'd1, 3'd5, 7'h20, 32'h3, 0, 1, 2'd0, 1, 5'd5, 3, 0));
    e = mk(3, 32'h8, 32'hC, 4'd2, 3'd0, 7'h00, 32'h8, 0, 1, 2'd1, 1, 5'd6, 7, 0);
    e.mem = 1'b1; e.mwe = 1'b0; e.mf3 = 3'd2; e.maddr = 32'h208;
    issue(32'h0080A303, 32'h208, 3, e);
    issue(32'h0140006F, 32'h20, 0, mk(4, 32'hC, 32'h20, 4'd5, 3'd0, 7'h00, 32'h14, 1, 1, 2'd2, 0, 5'd0, 3, 0));
    issue(32'h00208863, 32'h1, 0, mk(5, 32'h20, 32'h30, 4'd3, 3'd0, 7'h00, 32'h10, 0, 0, 2'd0, 0, 5'd16, 3, 0));
    issue(32'hFF1FF06F, 32'h20, 0, mk(6, 32'h30, 32'h20, 4'd5, 3'd0, 7'h00, 32'hFFFFFFF0, 1, 1, 2'd2, 0, 5'd0, 3, 0));
    issue(32'h00208863, 32'h0, 0, mk(7, 32'h20, 32'h24, 4'd3, 3'd0, 7'h00, 32'h10, 0, 0, 2'd0, 0, 5'd16, 3, 0));
    issue(32'h000100E7, 32'h101, 0, mk(8, 32'h24, 32'h100, 4'd2, 3'd0, 7'h00, 32'h0, 0, 1, 2'd2, 1, 5'd1, 3, 0));
    issue(32'h00500013, 32'h5, 0, mk(9, 32'h100, 32'h104, 4'd1, 3'd0, 7'h00, 32'h5, 0, 1, 2'd0, 0, 5'd0, 3, 0));
    e = mk(10, 32'h104, 32'h108, 4'd2, 3'd0, 7'h00, 32'hC, 0, 1, 2'd0, 0, 5'd12, 4, 0);
    e.mem = 1'b1; e.mwe = 1'b1; e.mf3 = 3'd2; e.maddr = 32'h1000;
    issue(32'h0020A623, 32'h1000, 0, e);
    issue(32'h123453B7, 32'h12345000, 0, mk(11, 32'h108, 32'h10C, 4'd4, 3'd0, 7'h00, 32'h12345000, 0, 1, 2'd0, 1, 5'd7, 3, 0));
    issue(32'h000100E7, 32'h102, 0, mk(12, 32'h10C, 32'h10C, 4'd2, 3'd0, 7'h00, 32'h0, 0, 1, 2'd2, 0, 5'd1, 3, 1));
    check_halt();
    flush();

    do_reset(1'b1);
    issue(32'h0000007F, 32'h0, 0, mk(13, 32'h0, 32'h0, 4'd7, 3'd0, 7'h00, 32'h0, 0, 0, 2'd0, 0, 5'd0, 3, 1));
    check_halt();
    flush();

    do_reset(1'b0);
    issue(32'h00500013, 32'h5, 0, mk(14, 32'h0, 32'h4, 4'd1, 3'd0, 7'h00, 32'h5, 0, 1, 2'd0, 0, 5'd0, 3, 0));
    wait_req();
    flush();
    chk("midfetch_imem_req", 32'(imem_req), 32'(1));
    chk("midfetch_imem_addr", imem_addr, 32'h4);
    do_reset(1'b0);
    issue(32'h002081B3, 32'h77, 0, mk(15, 32'h0, 32'h4, 4'd0, 3'd0, 7'h00, 32'h0, 0, 0, 2'd0, 1, 5'd3, 3, 0));
    wait_req();
    flush();
    chk("queue_drained", 32'(q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
